// File: rtl/mm_tree_sequencer.sv
// mm_tree_sequencer: issues one (row,col) dot product per ready cycle into the
// multiply/adder-tree datapath, tracks each issue through the fixed tree latency
// and raises the result-memory write strobe as the sum leaves the tree.
// Build option: define MM_STALL_CNT_EN to get a saturating count of stalled
// ISSUE cycles on stall_cnt; otherwise stall_cnt is tied to zero.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | presenting operands, one (row,col) per cycle with opnd_rdy
// DRAIN | everything issued, waiting for the tracker to empty
// DONE  | single-cycle completion pulse, then back to IDLE

module mm_tree_sequencer #(
  parameter int MATRIX_DIM = 8,
  parameter int PIPE_LAT   = 4,
  parameter int IDX_W      = $clog2(MATRIX_DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             opnd_rdy,
  output logic             issue_vld,
  output logic [IDX_W-1:0] a_row,
  output logic [IDX_W-1:0] b_col,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_row,
  output logic [IDX_W-1:0] wr_col,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MATRIX_DIM - 1);

  state_t state;
  state_t state_nxt;

  logic [IDX_W-1:0] row_q;
  logic [IDX_W-1:0] col_q;
  logic             last_issue;
  logic             pend;

  logic [PIPE_LAT-1:0]            trk_vld;
  logic [PIPE_LAT-1:0][IDX_W-1:0] trk_row;
  logic [PIPE_LAT-1:0][IDX_W-1:0] trk_col;

  assign last_issue = issue_vld && (row_q == IDX_MAX) && (col_q == IDX_MAX);

  // The tail entry is written this cycle, so only the younger stages decide
  // whether anything is still in flight after the next shift.
  if (PIPE_LAT > 1) begin : g_pend
    assign pend = |trk_vld[PIPE_LAT-2:0];
  end else begin : g_no_pend
    assign pend = 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)      state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (!pend)      state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Moore/Mealy outputs decoded from state
  always_comb begin
    issue_vld = (state == ISSUE) && opnd_rdy;
    busy      = (state == ISSUE) || (state == DRAIN);
    done      = (state == DONE);
  end

  // Row-major issue counters; the last issue wraps both back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (issue_vld) begin
      col_q <= col_q + 1'b1;
      if (col_q == IDX_MAX) row_q <= row_q + 1'b1;
    end
  end

  assign a_row = row_q;
  assign b_col = col_q;

  // Tracker mirrors the tree: shifts every cycle, bubbles enter as invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_vld <= '0;
      trk_row <= '0;
      trk_col <= '0;
    end else begin
      trk_vld[0] <= issue_vld;
      trk_row[0] <= row_q;
      trk_col[0] <= col_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        trk_vld[i] <= trk_vld[i-1];
        trk_row[i] <= trk_row[i-1];
        trk_col[i] <= trk_col[i-1];
      end
    end
  end

  assign wr_en  = trk_vld[PIPE_LAT-1];
  assign wr_row = trk_row[PIPE_LAT-1];
  assign wr_col = trk_col[PIPE_LAT-1];

`ifdef MM_STALL_CNT_EN
  logic [15:0] stall_q;

  // Stalled ISSUE cycles of the current/last job, saturating, kept after the job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state == IDLE) && start) begin
      stall_q <= '0;
    end else if ((state == ISSUE) && !opnd_rdy && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mm_tree_sequencer.sv
// Self-checking bench for mm_tree_sequencer. Each scenario is a per-cycle
// start/opnd_rdy schedule; a schedule-level reference model derives the
// expected outputs for every cycle by counting ready cycles from each job start.
// Cycle n is the clock period that ends at rising edge n.

module tb_mm_tree_sequencer;

  localparam int DIM  = 8;
  localparam int LAT  = 4;
  localparam int NIDX = DIM * DIM;
  localparam int MAXN = 320;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        opnd_rdy;
  logic        issue_vld;
  logic [2:0]  a_row;
  logic [2:0]  b_col;
  logic        wr_en;
  logic [2:0]  wr_row;
  logic [2:0]  wr_col;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  mm_tree_sequencer #(.MATRIX_DIM(DIM), .PIPE_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opnd_rdy  (opnd_rdy),
    .issue_vld (issue_vld),
    .a_row     (a_row),
    .b_col     (b_col),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit t_start[MAXN];
  bit t_rdy[MAXN];
  bit e_iv[MAXN];
  bit e_we[MAXN];
  bit e_busy[MAXN];
  bit e_done[MAXN];
  bit e_sv[MAXN];
  int e_k[MAXN];
  int e_w[MAXN];
  int e_stall[MAXN];

  int o_wr, o_last_wr, o_done1, o_done2, o_iss2;

  typedef struct {
    int st_lo;  int st_hi;  int p1;     int p2;
    int rdy_lo; int rdy_hi; int n;
    int x_wr;   int x_last; int x_done1; int x_done2; int x_iss2; int x_stall;
  } scn_t;

  scn_t tab[4];

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fill_scn(input scn_t s);
    for (int j = 0; j < MAXN; j++) begin
      t_start[j] = ((j >= s.st_lo) && (j <= s.st_hi)) || (j == s.p1) || (j == s.p2);
      t_rdy[j]   = !((j >= s.rdy_lo) && (j <= s.rdy_hi));
    end
  endtask

  // Reference: a job sampled at cycle j issues index k on the k-th ready cycle
  // from j+1, writes it LAT cycles later, and completes LAT+1 cycles after the
  // last issue; the next start is looked for the cycle after completion.
  task automatic build_model(input int n);
    int j, s, k, c, cnt, d;
    for (int i = 0; i < MAXN; i++) begin
      e_iv[i] = 0; e_we[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_sv[i] = 0;
      e_k[i] = 0;  e_w[i] = 0;  e_stall[i] = 0;
    end
    j = 0;
    while (j < n) begin
      if (!t_start[j]) begin
        j++;
        continue;
      end
      s = j + 1; k = 0; c = s; cnt = 0;
      while ((k < NIDX) && (c < n)) begin
        e_busy[c] = 1; e_sv[c] = 1; e_k[c] = k; e_stall[c] = cnt;
        if (t_rdy[c]) begin
          e_iv[c] = 1;
          if (c + LAT < MAXN) begin
            e_we[c+LAT] = 1;
            e_w[c+LAT]  = k;
          end
          k++;
        end else begin
          cnt++;
        end
        c++;
      end
      for (int m = c; m < n; m++) begin
        e_sv[m] = 1; e_stall[m] = cnt;
        if (m < c + LAT) e_busy[m] = 1;
      end
      if (k < NIDX) break;
      d = c + LAT;
      if (d < n) e_done[d] = 1;
      j = d + 1;
    end
  endtask

  task automatic run_sched(input int n);
    o_wr = 0; o_last_wr = -1; o_done1 = -1; o_done2 = -1; o_iss2 = -1;
    for (int j = 0; j < n; j++) begin
      start    = t_start[j];
      opnd_rdy = t_rdy[j];
      @(negedge clk);
      chk("ctl{iv,we,busy,done}", j, {28'd0, issue_vld, wr_en, busy, done},
          {28'd0, e_iv[j], e_we[j], e_busy[j], e_done[j]});
      chk("issue_idx", j, {26'd0, a_row, b_col}, e_k[j]);
      if (e_we[j]) chk("wr_idx", j, {26'd0, wr_row, wr_col}, e_w[j]);
`ifdef MM_STALL_CNT_EN
      if (e_sv[j]) chk("stall_cnt", j, {16'd0, stall_cnt}, e_stall[j]);
`else
      chk("stall_cnt_off", j, {16'd0, stall_cnt}, 32'd0);
`endif
      if (wr_en) begin
        o_wr++;
        o_last_wr = j;
      end
      if (done) begin
        if (o_done1 < 0)      o_done1 = j;
        else if (o_done2 < 0) o_done2 = j;
      end
      if (issue_vld && (o_done1 >= 0) && (o_iss2 < 0)) o_iss2 = j;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic apply_scn(input int i);
    fill_scn(tab[i]);
    build_model(tab[i].n);
    run_sched(tab[i].n);
    chk($sformatf("scn%0d_wr_count", i), i, o_wr, tab[i].x_wr);
    chk($sformatf("scn%0d_last_wr", i), i, o_last_wr, tab[i].x_last);
    chk($sformatf("scn%0d_done1", i), i, o_done1, tab[i].x_done1);
    chk($sformatf("scn%0d_done2", i), i, o_done2, tab[i].x_done2);
    chk($sformatf("scn%0d_iss2", i), i, o_iss2, tab[i].x_iss2);
`ifdef MM_STALL_CNT_EN
    chk($sformatf("scn%0d_stall_end", i), i, {16'd0, stall_cnt}, tab[i].x_stall);
`else
    chk($sformatf("scn%0d_stall_end", i), i, {16'd0, stall_cnt}, 32'd0);
`endif
  endtask

  initial begin
    //           st_lo st_hi p1    p2    rdy_lo rdy_hi n    wr   last done1 done2 iss2 stall
    tab[0] = '{0,    0,    -100, -100, -100,  -101,  72,  64,  68,  69,  -1,   -1,  0};
    tab[1] = '{0,    0,    -100, -100, 10,    12,    75,  64,  71,  72,  -1,   -1,  3};
    tab[2] = '{0,    0,    20,   68,   -100,  -101,  72,  64,  68,  69,  -1,   -1,  0};
    tab[3] = '{0,    100,  -100, -100, -100,  -101,  142, 128, 138, 69,  139,  71,  0};

    rst_n    = 1'b0;
    start    = 1'b1;
    opnd_rdy = 1'b1;
    #12;
    chk("reset_outputs", -1,
        {issue_vld, a_row, b_col, wr_en, wr_row, wr_col, busy, done, stall_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) apply_scn(i);

    // Abort a job with reset while results are still flowing out of the tree
    fill_scn(tab[0]);
    build_model(tab[0].n);
    run_sched(30);
    rst_n    = 1'b0;
    start    = 1'b1;
    opnd_rdy = 1'b1;
    #1;
    chk("abort_outputs_now", 30,
        {issue_vld, a_row, b_col, wr_en, wr_row, wr_col, busy, done, stall_cnt}, 32'd0);
    chk("abort_no_done", 30, o_done1, -1);
    @(negedge clk);
    chk("abort_outputs_held", 30,
        {issue_vld, a_row, b_col, wr_en, wr_row, wr_col, busy, done, stall_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    apply_scn(0);

    // Random ready patterns and stray starts against the schedule model
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < MAXN; j++) begin
        t_rdy[j]   = ($urandom_range(0, 3) != 0);
        t_start[j] = (j == 0) || ((j < 120) && ($urandom_range(0, 29) == 0));
      end
      build_model(220);
      run_sched(220);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
